// File: rtl/dm_write_buffer_if.sv
// Store / memory-write / load-forwarding bundle for dm_write_buffer.
//
// Handshake rules, in one place:
//   store port : a store transfers on a rising edge where st_valid && st_ready.
//                st_ready depends only on registered occupancy, never on st_valid.
//   memory port: mem_we/mem_addr/mem_wdata/mem_be are registered and held stable
//                until an edge with mem_ack=1 while mem_we=1; that edge completes
//                the write. mem_ack while mem_we=0 means nothing.
//   load port  : ld_hit/ld_data/ld_be are a pure combinational lookup of ld_addr.
interface dm_write_buffer_if #(parameter int AW = 32);
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic [1:0]    st_size;
  logic          st_err;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_ack;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [31:0]   ld_data;
  logic [3:0]    ld_be;
  logic          empty;
  logic          dbg_state;  // drain FSM state: 0 idle, 1 write

  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_ack, ld_addr,
    output st_ready, st_err, mem_we, mem_addr, mem_wdata, mem_be,
           ld_hit, ld_data, ld_be, empty, dbg_state
  );

  modport master (
    output st_valid, st_addr, st_data, st_size, mem_ack, ld_addr,
    input  st_ready, st_err, mem_we, mem_addr, mem_wdata, mem_be,
           ld_hit, ld_data, ld_be, empty, dbg_state
  );
endinterface

// File: rtl/dm_write_buffer.sv
// Store write buffer: aligns byte/half/word stores into lane-enabled words,
// queues them in program order, drains them to data memory and forwards
// pending data to loads.
module dm_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input logic             clk,
  input logic             reset,
  dm_write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;
  state_t state;

  logic [AW-3:0] ent_addr [DEPTH];
  logic [31:0]   ent_data [DEPTH];
  logic [3:0]    ent_be   [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic          al_legal;
  logic [3:0]    al_be;
  logic [31:0]   al_data;
  logic [4:0]    al_shift;
  logic          offer, push, reject, pop;

  logic          from_buf, nx_valid;
  logic [PW-1:0] src_idx;
  logic [AW-3:0] nx_addr;
  logic [31:0]   nx_data;
  logic [3:0]    nx_be;

  logic [PW-1:0] f_idx;
  logic [31:0]   f_data;
  logic [3:0]    f_be;

  assign bus.st_ready  = (count < CW'(DEPTH));
  assign bus.empty     = (count == '0);
  assign bus.dbg_state = (state == WRITE);

  // Lane-align the incoming store and decide whether its size/offset is legal.
  always_comb begin
    al_legal = 1'b0;
    al_be    = 4'b0000;
    al_data  = 32'h0;
    al_shift = {bus.st_addr[1:0], 3'b000};
    case (bus.st_size)
      2'b00: begin
        al_legal = 1'b1;
        al_be    = 4'b0001 << bus.st_addr[1:0];
        al_data  = {24'h0, bus.st_data[7:0]} << al_shift;
      end
      2'b01: begin
        al_legal = ~bus.st_addr[0];
        al_be    = 4'b0011 << bus.st_addr[1:0];
        al_data  = {16'h0, bus.st_data[15:0]} << al_shift;
      end
      2'b10: begin
        al_legal = (bus.st_addr[1:0] == 2'b00);
        al_be    = 4'b1111;
        al_data  = bus.st_data;
      end
      default: ;
    endcase
  end

  assign offer  = bus.st_valid & bus.st_ready;
  assign push   = offer & al_legal;
  assign reject = offer & ~al_legal;
  assign pop    = bus.mem_we & bus.mem_ack;

  // Pick what the memory port presents next: the oldest buffered entry that is
  // not the one completing now, or the store arriving this edge when the buffer
  // has nothing else (so an empty buffer writes out one cycle after accept).
  always_comb begin
    src_idx  = (state == WRITE) ? rd_ptr + PW'(1) : rd_ptr;
    from_buf = (state == WRITE) ? (count > CW'(1)) : (count != '0);
    nx_addr  = from_buf ? ent_addr[src_idx] : bus.st_addr[AW-1:2];
    nx_data  = from_buf ? ent_data[src_idx] : al_data;
    nx_be    = from_buf ? ent_be[src_idx]   : al_be;
    nx_valid = from_buf | push;
  end

  // Occupancy, pointers and the one-cycle reject pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      bus.st_err <= 1'b0;
    end else begin
      bus.st_err <= reject;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Entry storage; validity is tracked by rd_ptr/count so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_ptr] <= bus.st_addr[AW-1:2];
      ent_data[wr_ptr] <= al_data;
      ent_be[wr_ptr]   <= al_be;
    end
  end

  // Drain FSM with registered memory-port outputs held until acknowledged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= 32'h0;
      bus.mem_be    <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (nx_valid) begin
            state         <= WRITE;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= {nx_addr, 2'b00};
            bus.mem_wdata <= nx_data;
            bus.mem_be    <= nx_be;
          end
        end
        WRITE: begin
          if (pop) begin
            if (nx_valid) begin
              bus.mem_addr  <= {nx_addr, 2'b00};
              bus.mem_wdata <= nx_data;
              bus.mem_be    <= nx_be;
            end else begin
              state      <= IDLE;
              bus.mem_we <= 1'b0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          bus.mem_we <= 1'b0;
        end
      endcase
    end
  end

  // Forwarding: walk entries oldest to newest so newer lanes overwrite older.
  always_comb begin
    f_data = 32'h0;
    f_be   = 4'b0000;
    f_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      f_idx = rd_ptr + PW'(k);
      if ((CW'(k) < count) && (ent_addr[f_idx] == bus.ld_addr[AW-1:2])) begin
        for (int l = 0; l < 4; l++) begin
          if (ent_be[f_idx][l]) f_data[8*l +: 8] = ent_data[f_idx][8*l +: 8];
        end
        f_be = f_be | ent_be[f_idx];
      end
    end
  end

  assign bus.ld_data = f_data;
  assign bus.ld_be   = f_be;
  assign bus.ld_hit  = |f_be;
endmodule

// File: tb/tb_dm_write_buffer.sv
// Testbench for dm_write_buffer: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_dm_write_buffer;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;

  dm_write_buffer_if #(.AW(32)) bus();

  dm_write_buffer #(.DEPTH(DEPTH), .AW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Pending stores in program order: {word address[29:0], lane data[31:0], be[3:0]}
  logic [65:0] exp_q[$];
  logic        exp_err;
  int          checks;
  int          errors;

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference alignment, straight from the size/offset rules.
  function automatic void align(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                                output logic ok, output logic [3:0] be, output logic [31:0] w);
    int lane;
    lane = int'(a[1:0]);
    ok = 1'b0; be = 4'h0; w = 32'h0;
    case (sz)
      2'd0: begin ok = 1'b1; be = 4'(1 << lane); w = (d & 32'hFF) << (8 * lane); end
      2'd1: begin ok = (lane % 2 == 0); be = 4'(3 << lane); w = (d & 32'hFFFF) << (8 * lane); end
      2'd2: begin ok = (lane == 0); be = 4'hF; w = d; end
      default: ok = 1'b0;
    endcase
  endfunction

  // Reference forwarding: replay pending stores oldest-first onto an empty word.
  function automatic void fwd(input logic [31:0] la, output logic [31:0] d, output logic [3:0] be);
    logic [65:0] e;
    d = 32'h0; be = 4'h0;
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      if (e[65:36] == la[31:2]) begin
        for (int l = 0; l < 4; l++) begin
          if (e[l]) begin
            d[8*l +: 8] = e[4 + 8*l +: 8];
            be[l] = 1'b1;
          end
        end
      end
    end
  endfunction

  task automatic compare_all();
    logic [31:0] fd;
    logic [3:0]  fb;
    logic [65:0] h;
    chk("mem_we", {31'h0, bus.mem_we}, {31'h0, exp_q.size() > 0});
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      chk("mem_addr", bus.mem_addr, {h[65:36], 2'b00});
      chk("mem_wdata", bus.mem_wdata, h[35:4]);
      chk("mem_be", {28'h0, bus.mem_be}, {28'h0, h[3:0]});
    end
    chk("empty", {31'h0, bus.empty}, {31'h0, exp_q.size() == 0});
    chk("st_ready", {31'h0, bus.st_ready}, {31'h0, exp_q.size() < DEPTH});
    chk("st_err", {31'h0, bus.st_err}, {31'h0, exp_err});
    fwd(bus.ld_addr, fd, fb);
    chk("ld_be", {28'h0, bus.ld_be}, {28'h0, fb});
    chk("ld_data", bus.ld_data, fd);
    chk("ld_hit", {31'h0, bus.ld_hit}, {31'h0, |fb});
  endtask

  // One clock: advance the model with the current inputs, then compare.
  task automatic cycle();
    logic        ok, ready, do_pop, do_push;
    logic [3:0]  be;
    logic [31:0] w;
    align(bus.st_size, bus.st_addr, bus.st_data, ok, be, w);
    ready   = exp_q.size() < DEPTH;
    do_pop  = (exp_q.size() > 0) && bus.mem_ack;
    do_push = bus.st_valid && ready && ok;
    @(posedge clk);
    exp_err = bus.st_valid && ready && !ok;
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back({bus.st_addr[31:2], w, be});
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    bus.st_valid = 1'b0;
    bus.st_size  = 2'd0;
    bus.st_addr  = 32'h0;
    bus.st_data  = 32'h0;
    bus.mem_ack  = 1'b0;
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    bus.st_valid = 1'b1;
    bus.st_size  = sz;
    bus.st_addr  = a;
    bus.st_data  = d;
    cycle();
    bus.st_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    exp_err = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_mem_be", {28'h0, bus.mem_be}, 32'h0);
    chk("rst_st_err", {31'h0, bus.st_err}, 32'h0);
    chk("rst_ld_hit", {31'h0, bus.ld_hit}, 32'h0);
    chk("rst_ld_data", bus.ld_data, 32'h0);
    chk("rst_ld_be", {28'h0, bus.ld_be}, 32'h0);
    chk("rst_st_ready", {31'h0, bus.st_ready}, 32'h1);
    chk("rst_empty", {31'h0, bus.empty}, 32'h1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks  = 0;
    errors  = 0;
    exp_err = 1'b0;
    reset   = 1'b1;
    idle_inputs();
    bus.ld_addr = 32'h0;

    //           size   addr        data          err   maddr       be     wdata
    vecs[0] = '{2'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h10, 4'hF, 32'hDEADBEEF};
    vecs[1] = '{2'd0, 32'h23, 32'h000000AB, 1'b0, 32'h20, 4'h8, 32'hAB000000};
    vecs[2] = '{2'd1, 32'h22, 32'h00001234, 1'b0, 32'h20, 4'hC, 32'h12340000};
    vecs[3] = '{2'd1, 32'h21, 32'h00005678, 1'b1, 32'h0,  4'h0, 32'h0};
    vecs[4] = '{2'd2, 32'h22, 32'h01234567, 1'b1, 32'h0,  4'h0, 32'h0};
    vecs[5] = '{2'd3, 32'h30, 32'hFFFFFFFF, 1'b1, 32'h0,  4'h0, 32'h0};
    vecs[6] = '{2'd0, 32'h05, 32'hFFFFFF5A, 1'b0, 32'h04, 4'h2, 32'h00005A00};
    vecs[7] = '{2'd1, 32'h08, 32'hCAFEBEEF, 1'b0, 32'h08, 4'h3, 32'h0000BEEF};
    vecs[8] = '{2'd2, 32'h7C, 32'h01020304, 1'b0, 32'h7C, 4'hF, 32'h01020304};
    vecs[9] = '{2'd0, 32'h00, 32'h00000011, 1'b0, 32'h00, 4'h1, 32'h00000011};

    do_reset();

    // Directed vectors: one store each with mem_ack held high.
    for (int i = 0; i < 10; i++) begin
      bus.mem_ack = 1'b1;
      store(vecs[i].size, vecs[i].addr, vecs[i].data);
      if (vecs[i].err) begin
        chk("tbl_err", {31'h0, bus.st_err}, 32'h1);
        chk("tbl_err_empty", {31'h0, bus.empty}, 32'h1);
      end else begin
        chk("tbl_we", {31'h0, bus.mem_we}, 32'h1);
        chk("tbl_addr", bus.mem_addr, vecs[i].maddr);
        chk("tbl_be", {28'h0, bus.mem_be}, {28'h0, vecs[i].be});
        chk("tbl_wdata", bus.mem_wdata, vecs[i].wdata);
      end
      cycle();
      chk("tbl_drained", {31'h0, bus.empty}, 32'h1);
      chk("tbl_err_once", {31'h0, bus.st_err}, 32'h0);
      bus.mem_ack = 1'b0;
    end

    // Fill to capacity with no ack, then drain one ack at a time.
    for (int i = 0; i < 4; i++) store(2'd2, 32'(4 * i), 32'hA0 + 32'(i));
    chk("full_ready", {31'h0, bus.st_ready}, 32'h0);
    chk("full_head", bus.mem_addr, 32'h0);
    store(2'd2, 32'h10, 32'hBAD0BAD0);
    chk("full_reject_head", bus.mem_addr, 32'h0);
    chk("full_reject_ready", {31'h0, bus.st_ready}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("order_addr", bus.mem_addr, 32'(4 * i));
      chk("order_data", bus.mem_wdata, 32'hA0 + 32'(i));
      bus.mem_ack = 1'b1;
      cycle();
      bus.mem_ack = 1'b0;
      cycle();
    end
    chk("order_empty", {31'h0, bus.empty}, 32'h1);

    // Forwarding merge of a word and a newer byte in the same word.
    store(2'd2, 32'h40, 32'h11223344);
    store(2'd0, 32'h41, 32'h000000AA);
    bus.ld_addr = 32'h40;
    #1;
    chk("fwd_hit", {31'h0, bus.ld_hit}, 32'h1);
    chk("fwd_be", {28'h0, bus.ld_be}, 32'hF);
    chk("fwd_data", bus.ld_data, 32'h1122AA44);
    bus.ld_addr = 32'h44;
    #1;
    chk("fwd_miss_hit", {31'h0, bus.ld_hit}, 32'h0);
    chk("fwd_miss_data", bus.ld_data, 32'h0);
    bus.mem_ack = 1'b1;
    cycle();
    cycle();
    bus.mem_ack = 1'b0;
    chk("fwd_drained", {31'h0, bus.empty}, 32'h1);

    // Reset in the middle of a pending write, with a same-cycle ack.
    store(2'd2, 32'h80, 32'h1);
    store(2'd2, 32'h84, 32'h2);
    store(2'd2, 32'h88, 32'h3);
    chk("mid_we_before", {31'h0, bus.mem_we}, 32'h1);
    #2;
    reset = 1'b1;
    bus.mem_ack = 1'b1;
    #1;
    chk("mid_we_drop", {31'h0, bus.mem_we}, 32'h0);
    chk("mid_empty", {31'h0, bus.empty}, 32'h1);
    chk("mid_ready", {31'h0, bus.st_ready}, 32'h1);
    exp_q.delete();
    exp_err = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.mem_ack = 1'b0;
    store(2'd2, 32'h90, 32'h5555AAAA);
    chk("post_rst_we", {31'h0, bus.mem_we}, 32'h1);
    chk("post_rst_addr", bus.mem_addr, 32'h90);
    chk("post_rst_data", bus.mem_wdata, 32'h5555AAAA);
    bus.mem_ack = 1'b1;
    cycle();
    bus.mem_ack = 1'b0;

    // Randomized traffic on a small address window so forwarding hits often.
    for (int n = 0; n < 400; n++) begin
      bus.st_valid = 1'($urandom_range(0, 1));
      bus.st_size  = 2'($urandom_range(0, 3));
      bus.st_addr  = 32'h100 + 32'($urandom_range(0, 15));
      bus.st_data  = $urandom;
      bus.ld_addr  = 32'h100 + 32'($urandom_range(0, 15));
      bus.mem_ack  = ($urandom_range(0, 3) == 0);
      cycle();
    end
    idle_inputs();
    bus.mem_ack = 1'b1;
    for (int n = 0; n < DEPTH + 1; n++) cycle();
    chk("final_empty", {31'h0, bus.empty}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_write_buffer.md
Name: dm_write_buffer

Overview:
- Write-side companion to DataMemory: accepts store requests (byte/half/word) from the datapath.
- Aligns each store into a 32-bit word with byte enables and queues it in a small FIFO.
- Drains the FIFO into the data memory's write port with a valid/ack handshake.
- Provides combinational store-to-load forwarding so loads see pending stores before they reach memory.

Parameters:
DEPTH, 4, number of buffered store entries (power of 2, >=2)
AW, 32, byte address width

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
st_valid  input  1  store request present
st_ready  output  1  buffer can accept a store this cycle
st_addr  input  AW  byte address of store
st_data  input  32  store data, right-justified (byte in [7:0], half in [15:0])
st_size  input  2  00 byte, 01 half, 10 word, 11 illegal
st_err  output  1  one-cycle pulse: store rejected (misaligned/illegal size)
mem_we  output  1  write request to data memory
mem_addr  output  AW  word-aligned address, [1:0] always 00
mem_wdata  output  32  lane-aligned write data
mem_be  output  4  byte enables, bit i = bits [8i+7:8i]
mem_ack  input  1  memory accepted current write at this edge
ld_addr  input  AW  load address for forwarding lookup
ld_hit  output  1  some pending entry covers word of ld_addr
ld_data  output  32  merged forwarded data (valid lanes only)
ld_be  output  4  lanes supplied by ld_data
empty  output  1  no pending entries

Behaviour:
- Reset (async, immediate):
  - All entries invalid; count=0; pointers=0.
  - mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
  - st_err=0, ld_hit=0, ld_data=0, ld_be=0.
  - st_ready=1, empty=1.
- Alignment, lane a = st_addr[1:0]:
  - Byte: be = 0001<<a; wdata lane a = st_data[7:0].
  - Half: requires a[0]=0; be = 0011<<a; lanes a, a+1 = st_data[15:0].
  - Word: requires a=00; be=1111; wdata=st_data.
  - Unused lanes are 0.
- Accept: st_valid & st_ready & legal -> enqueue {addr[AW-1:2], wdata, be} at the clock edge.
- Reject: st_valid & st_ready & (misaligned or size=11) -> not enqueued; st_err=1 the following cycle for exactly one cycle.
- st_ready = (count < DEPTH). A full buffer does not accept even if a pop occurs in the same cycle.
- Drain FSM:
  - IDLE: mem_we=0; go to WRITE when count>0.
  - WRITE: mem_we=1; mem_addr/wdata/be = head entry, held stable until mem_ack.
  - On mem_ack: pop head. Stay in WRITE if count after pop >0, else return to IDLE.
  - mem_ack while mem_we=0 is ignored.
- Latency: a store accepted at edge N asserts mem_we no earlier than cycle N+1. No combinational st_valid -> mem_we path.
- Simultaneous push and pop: count unchanged; both pointers advance (mod DEPTH).
- Forwarding (combinational on ld_addr and buffer contents):
  - Compare ld_addr[AW-1:2] against every valid entry, including the head currently being written.
  - Per lane, take data from the newest matching entry that enables that lane.
  - ld_be = OR of matching entries' be; ld_hit = |ld_be.
  - Lanes without coverage read 0 in ld_data.
  - A store enqueued this edge is visible to forwarding from the next cycle.
- Entries are never coalesced; memory writes occur in program order.
- Reset asserted mid-write: the pending write is abandoned and mem_we drops immediately. The memory must not treat a same-cycle ack as a completed write.

Test Plan:
1. Reset, then word store addr=0x10, data=0xDEADBEEF, with mem_ack held 1 -> next cycle mem_we=1, mem_addr=0x10, mem_be=1111, mem_wdata=0xDEADBEEF; empty=1 after ack.
2. Byte store addr=0x23, data=0xAB -> mem_addr=0x20, mem_be=1000, mem_wdata=0xAB000000. Half store addr=0x22, data=0x1234 -> mem_be=1100, mem_wdata=0x12340000.
3. Half store addr=0x21 and word store addr=0x22 -> neither enqueued; st_err pulses once per request; empty stays 1.
4. mem_ack=0, push 4 word stores 0x0,0x4,0x8,0xC -> st_ready=0 after 4th; mem outputs frozen on entry 0x0. Pulse mem_ack 4 times -> writes in order 0x0,0x4,0x8,0xC, then empty=1.
5. mem_ack=0, store word 0x40=0x11223344, then byte 0x41=0xAA, ld_addr=0x40 -> ld_hit=1, ld_be=1111, ld_data=0x1122AA44. ld_addr=0x44 -> ld_hit=0, ld_data=0.
6. Buffer holding 3 entries, mem_we=1, then assert reset mid-cycle -> mem_we=0 and empty=1 immediately; after release, a new store writes normally.
